rx_tcp_chksum_arb: RTL

- Packet-level round-robin arbiter that shares one rx TCP format/output controller between NUM_SRC parallel rx checksum engines.
- Each engine presents a checksum-annotated stream: tdata/tkeep/tval/tlast plus csum.
- The arbiter selects one source, locks onto it until that packet's tlast beat is accepted, then rotates priority.
- Sits between the checksum engine array and the format controller's resp_* input; adds zero datapath latency.

---
 rtl/packet_struct_pkg.sv | 30 +++
 rtl/rr_prio_pick.sv | 35 +++
 rtl/rx_tcp_chksum_arb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/packet_struct_pkg.sv
// Shared packet-path types for the rx/tx stream blocks.
// Checksum result width is a codebase-wide macro.
`ifndef TCP_CHKSUM_W
`define TCP_CHKSUM_W 16
`endif

package packet_struct_pkg;

    localparam int RX_DATA_W    = 256;
    localparam int RX_KEEP_W    = RX_DATA_W / 8;
    localparam int TCP_CHKSUM_W = `TCP_CHKSUM_W;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } rx_arb_state_e;

    typedef struct packed {
        logic [RX_DATA_W-1:0]    tdata;
        logic [RX_KEEP_W-1:0]    tkeep;
        logic                    tlast;
        logic [TCP_CHKSUM_W-1:0] csum;
    } rx_chksum_resp_s;

    // Compare-and-reset so non power-of-two counts wrap correctly.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Round-robin priority pick: first request at or after ptr.
// Purely combinational; shared by the rx and tx arbiters.
module rr_prio_pick
    import packet_struct_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] scan;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        scan    = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_any && req[scan]) begin
                gnt_any = 1'b1;
                gnt_idx = scan;
            end
            scan = IDX_W'(rr_next(int'(scan), NUM_REQ));
        end
        if (gnt_any) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rx_tcp_chksum_arb.sv
// Packet-level round-robin arbiter from NUM_SRC rx checksum
// engines into one format controller; zero added latency.
module rx_tcp_chksum_arb
    import packet_struct_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_SRC    = 4,
    parameter int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_resp_tdata,
    input  logic [NUM_SRC*KEEP_WIDTH-1:0]   src_resp_tkeep,
    input  logic [NUM_SRC-1:0]              src_resp_tval,
    input  logic [NUM_SRC-1:0]              src_resp_tlast,
    input  logic [NUM_SRC*`TCP_CHKSUM_W-1:0] src_resp_csum,
    output logic [NUM_SRC-1:0]              src_resp_trdy,
    output logic [DATA_WIDTH-1:0]           dst_resp_tdata,
    output logic [KEEP_WIDTH-1:0]           dst_resp_tkeep,
    output logic                            dst_resp_tval,
    output logic                            dst_resp_tlast,
    output logic [`TCP_CHKSUM_W-1:0]        dst_resp_csum,
    input  logic                            dst_resp_trdy,
    output logic [SRC_W-1:0]                dst_resp_src_id,
    output logic                            arb_busy,
    output logic [31:0]                     arb_pkt_cnt
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    tdata;
        logic [KEEP_WIDTH-1:0]    tkeep;
        logic                     tlast;
        logic [`TCP_CHKSUM_W-1:0] csum;
    } resp_t;

    resp_t              src_arr [NUM_SRC];
    resp_t              cur;
    rx_arb_state_e      state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]        pkt_cnt_q, pkt_cnt_d;
    logic [SRC_W-1:0]   pick_idx, cur_idx;
    logic [NUM_SRC-1:0] pick_oh;
    logic               pick_any, present, accept;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_flat
        assign src_arr[i] = {
            src_resp_tdata[i*DATA_WIDTH +: DATA_WIDTH],
            src_resp_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
            src_resp_tlast[i],
            src_resp_csum[i*`TCP_CHKSUM_W +: `TCP_CHKSUM_W]
        };
    end

    rr_prio_pick #(
        .NUM_REQ (NUM_SRC),
        .IDX_W   (SRC_W)
    ) u_pick (
        .req     (src_resp_tval),
        .ptr     (rr_ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        cur_idx   = (state_q == LOCKED) ? grant_q : pick_idx;
        cur       = src_arr[cur_idx];
        present   = (state_q == LOCKED) || pick_any;

        dst_resp_tval   = 1'b0;
        dst_resp_tdata  = '0;
        dst_resp_tkeep  = '0;
        dst_resp_tlast  = 1'b0;
        dst_resp_csum   = '0;
        dst_resp_src_id = '0;
        src_resp_trdy   = '0;

        // Reset blocks any handshake in the cycle it is asserted.
        if (!rst && present) begin
            dst_resp_tval = (state_q == LOCKED)
                          ? src_resp_tval[grant_q] : 1'b1;
            dst_resp_tdata  = cur.tdata;
            dst_resp_tkeep  = cur.tkeep;
            dst_resp_tlast  = cur.tlast;
            dst_resp_csum   = cur.csum;
            dst_resp_src_id = cur_idx;
            src_resp_trdy   = (state_q == LOCKED)
                            ? '0 : pick_oh & {NUM_SRC{dst_resp_trdy}};
            if (state_q == LOCKED) begin
                src_resp_trdy[grant_q] = dst_resp_trdy;
            end
        end

        accept = dst_resp_tval && dst_resp_trdy;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    if (accept && cur.tlast) begin
                        rr_ptr_d  = SRC_W'(rr_next(int'(pick_idx), NUM_SRC));
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                    end else begin
                        grant_d = pick_idx;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (accept && cur.tlast) begin
                    rr_ptr_d  = SRC_W'(rr_next(int'(grant_q), NUM_SRC));
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign arb_busy    = !rst && (state_q == LOCKED);
    assign arb_pkt_cnt = pkt_cnt_q;

    a_trdy_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(src_resp_trdy));

    a_tval_src: assert property (@(posedge clk) disable iff (rst)
        dst_resp_tval |-> src_resp_tval[dst_resp_src_id]);

    a_hold: assert property (@(posedge clk) disable iff (rst)
        dst_resp_tval && !dst_resp_trdy |=>
        $stable({dst_resp_tdata, dst_resp_tkeep, dst_resp_tlast,
                 dst_resp_csum, dst_resp_src_id}));

endmodule
